// File: rtl/RSA_pkg.sv
// Shared types and constants for the RSA block and its word-collector front-end.
package RSA_pkg;

    localparam int MOD_WIDTH     = 256;
    localparam int WORD_WIDTH    = 32;
    localparam int WORDS_PER_KEY = MOD_WIDTH / WORD_WIDTH;
    localparam int CNT_WIDTH     = (WORDS_PER_KEY > 1) ? $clog2(WORDS_PER_KEY) : 1;

    typedef logic [MOD_WIDTH-1:0]  KeyType;
    typedef logic [WORD_WIDTH-1:0] WordType;

    typedef enum logic [1:0] {
        OP_MSG = 2'd0,
        OP_KEY = 2'd1,
        OP_MOD = 2'd2
    } OperandSel_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } CollectorState_t;

endpackage

// File: rtl/rsa_key_word_loader.sv
// One operand register, loaded a word slice at a time.
module rsa_key_word_loader
    import RSA_pkg::*;
#(
    parameter int WORD_WIDTH = RSA_pkg::WORD_WIDTH,
    parameter int KEY_WIDTH  = RSA_pkg::MOD_WIDTH,
    parameter int IDX_WIDTH  = RSA_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [IDX_WIDTH-1:0]  i_idx,
    input  logic [WORD_WIDTH-1:0] i_word,
    output logic [KEY_WIDTH-1:0]  o_data
);

    logic [KEY_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_we) begin
            r_data[i_idx*WORD_WIDTH +: WORD_WIDTH] <= i_word;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/rsa_word_collector.sv
// Assembles msg/key/modulus from a framed word stream and hands them to the RSA core
// as one valid/ready transaction; malformed frames are dropped with an o_err pulse.
module rsa_word_collector
    import RSA_pkg::*;
#(
    parameter int WORD_WIDTH = RSA_pkg::WORD_WIDTH,
    parameter int KEY_WIDTH  = RSA_pkg::MOD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [KEY_WIDTH-1:0]  o_msg,
    output logic [KEY_WIDTH-1:0]  o_key,
    output logic [KEY_WIDTH-1:0]  o_modulus,
    output logic                  o_err
);

    localparam int WPK   = KEY_WIDTH / WORD_WIDTH;
    localparam int CNT_W = (WPK > 1) ? $clog2(WPK) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WPK - 1);

    CollectorState_t  r_state, w_state_next;
    OperandSel_t      r_op_sel;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_err;

    logic w_accept;
    logic w_final_pos;
    logic w_done;
    logic w_frame_err;
    logic w_consume;
    logic w_we_msg, w_we_key, w_we_mod;

    assign w_accept    = i_valid && (r_state == ST_COLLECT);
    assign w_final_pos = (r_op_sel == OP_MOD) && (r_word_cnt == CNT_MAX);
    assign w_done      = w_accept && w_final_pos && i_last;
    // A frame is bad if i_last disagrees with the final-position check in either direction.
    assign w_frame_err = w_accept && (w_final_pos != i_last);
    assign w_consume   = (r_state == ST_HOLD) && o_ready;

    assign w_we_msg = w_accept && (r_op_sel == OP_MSG);
    assign w_we_key = w_accept && (r_op_sel == OP_KEY);
    assign w_we_mod = w_accept && (r_op_sel == OP_MOD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        i_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                i_ready = 1'b1;
                if (w_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
            r_op_sel   <= OP_MSG;
        end else if (w_consume || w_done || w_frame_err) begin
            r_word_cnt <= '0;
            r_op_sel   <= OP_MSG;
        end else if (w_accept) begin
            if (r_word_cnt == CNT_MAX) begin
                r_word_cnt <= '0;
                case (r_op_sel)
                    OP_MSG:  r_op_sel <= OP_KEY;
                    OP_KEY:  r_op_sel <= OP_MOD;
                    default: r_op_sel <= OP_MSG;
                endcase
            end else begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    // Errors only arise in COLLECT, which never drives o_valid, so the two cannot overlap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_frame_err;
        end
    end

    assign o_err = r_err;

    rsa_key_word_loader #(
        .WORD_WIDTH (WORD_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH),
        .IDX_WIDTH  (CNT_W)
    ) u_msg_loader (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we_msg),
        .i_idx  (r_word_cnt),
        .i_word (i_word),
        .o_data (o_msg)
    );

    rsa_key_word_loader #(
        .WORD_WIDTH (WORD_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH),
        .IDX_WIDTH  (CNT_W)
    ) u_key_loader (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we_key),
        .i_idx  (r_word_cnt),
        .i_word (i_word),
        .o_data (o_key)
    );

    rsa_key_word_loader #(
        .WORD_WIDTH (WORD_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH),
        .IDX_WIDTH  (CNT_W)
    ) u_mod_loader (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we_mod),
        .i_idx  (r_word_cnt),
        .i_word (i_word),
        .o_data (o_modulus)
    );

endmodule

// File: doc/rsa_word_collector.md
Name: rsa_word_collector

Overview:
- Upstream front-end of the RSA top block.
- Accepts a framed stream of narrow words from a host bus and assembles three MOD_WIDTH-bit operands: message, key and modulus.
- Presents the assembled operands as a single valid/ready transaction whose outputs connect directly to the RSA i_msg/i_key/i_modulus/i_valid/i_ready inputs.
- Detects framing errors and resynchronises on the next frame.

Parameters:
- WORD_WIDTH, 32, width of one input word; MOD_WIDTH must be an integer multiple of it.
- KEY_WIDTH, MOD_WIDTH (256, from RSA_pkg), width of each operand.
- WORDS_PER_KEY, KEY_WIDTH/WORD_WIDTH (8), derived; words per operand.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- i_valid  in  1  input word valid
- i_ready  out  1  collector can accept a word
- i_word  in  WORD_WIDTH  input data word
- i_last  in  1  marks the final word of a frame
- o_valid  out  1  assembled operand set valid
- o_ready  in  1  downstream (RSA) accepts the operand set
- o_msg  out  KEY_WIDTH  assembled message (KeyType)
- o_key  out  KEY_WIDTH  assembled exponent (KeyType)
- o_modulus  out  KEY_WIDTH  assembled modulus (KeyType)
- o_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Frame format: 3*WORDS_PER_KEY words (24 at defaults), in the order msg, key, modulus.
  - Each operand arrives least-significant word first: word k of an operand fills bits [k*WORD_WIDTH +: WORD_WIDTH].
- A word transfers when i_valid && i_ready on a rising clk edge.
- States:
  - COLLECT: i_ready=1, o_valid=0.
  - HOLD: i_ready=0, o_valid=1.
- Counters:
  - word_cnt runs 0..WORDS_PER_KEY-1 and wraps to 0 when an operand completes.
  - op_sel (MSG, KEY, MOD) advances on each word_cnt wrap.
- COLLECT, accepted word:
  - The word is written into the selected operand slice.
  - If op_sel=MOD, word_cnt=WORDS_PER_KEY-1 and i_last=1: go to HOLD; o_valid rises the next cycle (latency of 1 cycle from the final word accept).
  - If i_last=1 at any other position: framing error. Frame discarded, o_err=1 for exactly the next cycle, counters cleared, stay in COLLECT.
  - If at the final position with i_last=0: framing error, same handling as above.
  - Partially written operand registers are not cleared on error; the next frame overwrites them.
- HOLD:
  - o_msg/o_key/o_modulus and o_valid stay stable until o_ready=1.
  - On o_valid && o_ready: return to COLLECT with counters at 0; i_ready=1 in the following cycle.
- No skid buffer: a new frame cannot start in the same cycle the set is consumed. Throughput is at most one set per 3*WORDS_PER_KEY+1 cycles, gated by the consumer.
- o_ready while not in HOLD is ignored.
- Reset (asynchronous, rst low), also mid-frame or mid-HOLD:
  - state=COLLECT, word_cnt=0, op_sel=MSG.
  - o_valid=0, o_err=0, o_msg=o_key=o_modulus=0.
  - i_ready=1 once rst is released.
- i_ready is a combinational decode of state only; it never depends on i_valid.
- o_err and o_valid are never asserted in the same cycle.

Decomposition:
- RSA_pkg:
  - Existing: MOD_WIDTH and KeyType.
  - Add: WORD_WIDTH constant, WordType typedef, and the OperandSel_t enum {OP_MSG, OP_KEY, OP_MOD}.
- Sub-module rsa_key_word_loader, one instance per operand:
  - Holds one KeyType register.
  - Writes a WORD_WIDTH slice at index word_cnt when its write-enable is high.
  - Asynchronous active-low reset to 0.
- The top level contains the FSM, the counters, error detection and the three loader instances.

Test Plan:
- Single frame:
  - Stimulus: msg words 0x00000001..0x00000008, key words 0x10000001..0x10000008, modulus words 0xF0000001..0xF0000008, with i_last on word 24 and o_ready=1.
  - Response: o_valid rises 1 cycle after word 24; o_msg=0x00000008_..._00000001, o_key and o_modulus assembled likewise; i_ready=0 during HOLD.
- Backpressure:
  - Stimulus: the frame above with o_ready held 0 for 10 cycles.
  - Response: outputs and o_valid stable for all 10 cycles; i_ready=0; one transfer on the o_ready rise, then i_ready=1.
- Early i_last:
  - Stimulus: i_last asserted on word 5.
  - Response: o_err pulses exactly 1 cycle and o_valid stays 0; the next clean 24-word frame is assembled correctly.
- Missing i_last:
  - Stimulus: 24 words with i_last=0.
  - Response: o_err pulse, no o_valid; the following good frame is accepted.
- Gapped input:
  - Stimulus: i_valid toggled randomly (about 50%) across a frame.
  - Response: result identical to the single-frame case; no word is dropped or duplicated.
- Reset mid-operation:
  - Stimulus: assert rst at word 13, release, then send a full frame; repeat with reset during HOLD.
  - Response: all outputs 0 and o_valid=0 immediately on reset; the fresh frame is assembled correctly.
